// File: rtl/sha_pkg.sv
// Shared SHA-256 types, constants and round primitives for the multi-round pipeline stage.
package sha_pkg;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] d;
        logic [31:0] e;
        logic [31:0] f;
        logic [31:0] g;
        logic [31:0] h;
    } HashState;

    localparam int SHA_MODE_EXPAND   = 0;
    localparam int SHA_MODE_PRESERVE = 1;

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam HashState H_INIT = '{
        a: 32'h6a09e667, b: 32'hbb67ae85, c: 32'h3c6ef372, d: 32'ha54ff53a,
        e: 32'h510e527f, f: 32'h9b05688c, g: 32'h1f83d9ab, h: 32'h5be0cd19
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f,
                                       input logic [31:0] g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

endpackage

// File: rtl/sha_round_comb.sv
// One SHA-256 compression round at fixed index T plus one message-window step.
module sha_round_comb
    import sha_pkg::*;
#(
    parameter int T    = 0,
    parameter int MODE = SHA_MODE_EXPAND
) (
    input  HashState          state_cur,
    input  logic [15:0][31:0] w_cur,
    output HashState          state_nxt,
    output logic [15:0][31:0] w_nxt
);

    logic [31:0] t1;
    logic [31:0] t2;
    logic [31:0] new_word;

    always_comb begin
        t1 = state_cur.h + big_sigma1(state_cur.e) + ch(state_cur.e, state_cur.f, state_cur.g)
           + K[T] + w_cur[0];
        t2 = big_sigma0(state_cur.a) + maj(state_cur.a, state_cur.b, state_cur.c);

        state_nxt.h = state_cur.g;
        state_nxt.g = state_cur.f;
        state_nxt.f = state_cur.e;
        state_nxt.e = state_cur.d + t1;
        state_nxt.d = state_cur.c;
        state_nxt.c = state_cur.b;
        state_nxt.b = state_cur.a;
        state_nxt.a = t1 + t2;
    end

    // Preserve mode recirculates the consumed word so 16 steps restore the window.
    if (MODE == SHA_MODE_EXPAND) begin : g_expand
        assign new_word = small_sigma1(w_cur[14]) + w_cur[9] + small_sigma0(w_cur[1]) + w_cur[0];
    end else begin : g_preserve
        assign new_word = w_cur[0];
    end

    always_comb begin
        w_nxt        = '0;
        w_nxt[14:0]  = w_cur[15:1];
        w_nxt[15]    = new_word;
    end

endmodule

// File: rtl/sha_multi_round_stage.sv
// SHA-256 pipeline stage: ROUNDS combinational rounds from ROUND_BASE into one output register.
module sha_multi_round_stage
    import sha_pkg::*;
#(
    parameter int ROUNDS     = 1,
    parameter int ROUND_BASE = 0,
    parameter int MODE       = SHA_MODE_EXPAND
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              valid_i,
    input  logic              newblock_i,
    input  HashState          state_i,
    input  logic [15:0][31:0] W_i,
    output logic              valid_o,
    output logic              newblock_o,
    output HashState          state_o,
    output logic [15:0][31:0] W_o
);

    if (!(ROUNDS == 1 || ROUNDS == 2 || ROUNDS == 4)) begin : g_bad_rounds
        $error("sha_multi_round_stage: ROUNDS must be 1, 2 or 4 (got %0d)", ROUNDS);
    end
    if (ROUND_BASE < 0 || ROUND_BASE + ROUNDS > 64 || (ROUND_BASE % ROUNDS) != 0) begin : g_bad_base
        $error("sha_multi_round_stage: ROUND_BASE %0d misaligned or out of range", ROUND_BASE);
    end
    if (!(MODE == SHA_MODE_EXPAND || MODE == SHA_MODE_PRESERVE)) begin : g_bad_mode
        $error("sha_multi_round_stage: MODE must be 0 or 1 (got %0d)", MODE);
    end

    HashState          st_chain [0:ROUNDS];
    logic [15:0][31:0] w_chain  [0:ROUNDS];

    assign st_chain[0] = state_i;
    assign w_chain[0]  = W_i;

    // Each round sees the window already stepped by the previous round.
    for (genvar j = 0; j < ROUNDS; j++) begin : g_round
        sha_round_comb #(
            .T    (ROUND_BASE + j),
            .MODE (MODE)
        ) u_round (
            .state_cur (st_chain[j]),
            .w_cur     (w_chain[j]),
            .state_nxt (st_chain[j+1]),
            .w_nxt     (w_chain[j+1])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_o    <= 1'b0;
            newblock_o <= 1'b0;
            state_o    <= '0;
            W_o        <= '0;
        end else if (!stall_i) begin
            valid_o    <= valid_i;
            newblock_o <= newblock_i & valid_i;
            if (valid_i) begin
                state_o <= st_chain[ROUNDS];
                W_o     <= w_chain[ROUNDS];
            end
        end
    end

endmodule

// File: tb/tb_sha_multi_round_stage.sv
// Directed bench: single stages, a preserve chain and full 64-round chains on "abc".
module tb_sha_multi_round_stage;
    import sha_pkg::*;

    logic              clk = 1'b0;
    logic              rst, stall, vin, nbin;
    HashState          st_in;
    logic [15:0][31:0] w_in;

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Single stages
    logic v1o, n1o, v2o, n2o;
    HashState s1o, s2o;
    logic [15:0][31:0] w1o, w2o;

    sha_multi_round_stage #(.ROUNDS(1), .ROUND_BASE(0), .MODE(0)) d1 (
        .clk(clk), .rst(rst), .stall_i(stall), .valid_i(vin), .newblock_i(nbin),
        .state_i(st_in), .W_i(w_in), .valid_o(v1o), .newblock_o(n1o), .state_o(s1o), .W_o(w1o));

    sha_multi_round_stage #(.ROUNDS(2), .ROUND_BASE(0), .MODE(0)) d2 (
        .clk(clk), .rst(rst), .stall_i(stall), .valid_i(vin), .newblock_i(nbin),
        .state_i(st_in), .W_i(w_in), .valid_o(v2o), .newblock_o(n2o), .state_o(s2o), .W_o(w2o));

    // Preserve chain, 4 stages of 4 rounds
    logic pv [0:4];
    logic pn [0:4];
    HashState ps [0:4];
    logic [15:0][31:0] pw [0:4];
    assign pv[0] = vin; assign pn[0] = nbin; assign ps[0] = st_in; assign pw[0] = w_in;
    for (genvar k = 0; k < 4; k++) begin : g_pch
        sha_multi_round_stage #(.ROUNDS(4), .ROUND_BASE(4*k), .MODE(1)) u (
            .clk(clk), .rst(rst), .stall_i(stall), .valid_i(pv[k]), .newblock_i(pn[k]),
            .state_i(ps[k]), .W_i(pw[k]), .valid_o(pv[k+1]), .newblock_o(pn[k+1]),
            .state_o(ps[k+1]), .W_o(pw[k+1]));
    end

    // Full expand chains for ROUNDS = 1, 2, 4
    logic cv1 [0:64]; logic cn1 [0:64]; HashState cs1 [0:64]; logic [15:0][31:0] cw1 [0:64];
    logic cv2 [0:32]; logic cn2 [0:32]; HashState cs2 [0:32]; logic [15:0][31:0] cw2 [0:32];
    logic cv4 [0:16]; logic cn4 [0:16]; HashState cs4 [0:16]; logic [15:0][31:0] cw4 [0:16];
    assign cv1[0] = vin; assign cn1[0] = nbin; assign cs1[0] = st_in; assign cw1[0] = w_in;
    assign cv2[0] = vin; assign cn2[0] = nbin; assign cs2[0] = st_in; assign cw2[0] = w_in;
    assign cv4[0] = vin; assign cn4[0] = nbin; assign cs4[0] = st_in; assign cw4[0] = w_in;

    for (genvar k = 0; k < 64; k++) begin : g_c1
        sha_multi_round_stage #(.ROUNDS(1), .ROUND_BASE(k), .MODE(0)) u (
            .clk(clk), .rst(rst), .stall_i(stall), .valid_i(cv1[k]), .newblock_i(cn1[k]),
            .state_i(cs1[k]), .W_i(cw1[k]), .valid_o(cv1[k+1]), .newblock_o(cn1[k+1]),
            .state_o(cs1[k+1]), .W_o(cw1[k+1]));
    end
    for (genvar k = 0; k < 32; k++) begin : g_c2
        sha_multi_round_stage #(.ROUNDS(2), .ROUND_BASE(2*k), .MODE(0)) u (
            .clk(clk), .rst(rst), .stall_i(stall), .valid_i(cv2[k]), .newblock_i(cn2[k]),
            .state_i(cs2[k]), .W_i(cw2[k]), .valid_o(cv2[k+1]), .newblock_o(cn2[k+1]),
            .state_o(cs2[k+1]), .W_o(cw2[k+1]));
    end
    for (genvar k = 0; k < 16; k++) begin : g_c4
        sha_multi_round_stage #(.ROUNDS(4), .ROUND_BASE(4*k), .MODE(0)) u (
            .clk(clk), .rst(rst), .stall_i(stall), .valid_i(cv4[k]), .newblock_i(cn4[k]),
            .state_i(cs4[k]), .W_i(cw4[k]), .valid_o(cv4[k+1]), .newblock_o(cn4[k+1]),
            .state_o(cs4[k+1]), .W_o(cw4[k+1]));
    end

    localparam logic [255:0] DIGEST_ABC =
        256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;

    function automatic logic [255:0] feed_fwd(input HashState s);
        return {s.a + H_INIT.a, s.b + H_INIT.b, s.c + H_INIT.c, s.d + H_INIT.d,
                s.e + H_INIT.e, s.f + H_INIT.f, s.g + H_INIT.g, s.h + H_INIT.h};
    endfunction

    typedef struct {
        HashState          st;
        logic [15:0][31:0] w;
        logic              v;
        logic              nb;
        logic [31:0]       a, e, w15, w0;
    } vec_t;

    function automatic vec_t mk(input HashState s, input logic [15:0][31:0] w, input logic v,
                                input logic nb, input logic [31:0] a, input logic [31:0] e,
                                input logic [31:0] w15, input logic [31:0] w0);
        vec_t r;
        r.st = s; r.w = w; r.v = v; r.nb = nb; r.a = a; r.e = e; r.w15 = w15; r.w0 = w0;
        return r;
    endfunction

    vec_t              tbl [7];
    logic [15:0][31:0] abc, wz, wone, wv4, wv5, wseq, wrot, pw_exp;
    HashState          sz, sv4, sv5, sv6;
    int                cnt1, cnt2, cnt4;

    initial begin
        abc = '0; abc[0] = 32'h61626380; abc[15] = 32'h00000018;
        wz = '0;
        wone = '0; wone[0] = 32'h1;
        wv4 = '0; wv4[1] = 32'h80;
        wv5 = '0; wv5[14] = 32'h18;
        sz = '0;
        sv4 = '0; sv4.d = 32'h10;
        sv5 = '0; sv5.h = 32'h1; sv5.g = 32'hffffffff;
        sv6 = '0; sv6.a = 32'hffffffff; sv6.b = 32'hffffffff;

        tbl[0] = mk(H_INIT, abc,  1, 1, 32'h5d6aebcd, 32'hfa2a4622, 32'h61626380, 32'h0);
        tbl[1] = mk(sz,     wz,   1, 0, 32'h428a2f98, 32'h428a2f98, 32'h0,        32'h0);
        tbl[2] = mk(sz,     wone, 0, 1, 32'h428a2f98, 32'h428a2f98, 32'h0,        32'h0);
        tbl[3] = mk(sz,     wone, 1, 0, 32'h428a2f99, 32'h428a2f99, 32'h1,        32'h0);
        tbl[4] = mk(sv4,    wv4,  1, 0, 32'h428a2f98, 32'h428a2fa8, 32'h00200011, 32'h80);
        tbl[5] = mk(sv5,    wv5,  1, 1, 32'h428a2f98, 32'h428a2f98, 32'h000f0000, 32'h0);
        tbl[6] = mk(sv6,    wz,   1, 0, 32'h428a2f96, 32'h428a2f98, 32'h0,        32'h0);

        rst = 1'b1; stall = 1'b0; vin = 1'b0; nbin = 1'b0; st_in = '0; w_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset valid_o", v1o, 1'b0);
        chk("reset newblock_o", n1o, 1'b0);
        chk("reset state_o", s1o, '0);
        chk("reset W_o", w1o, '0);
        rst = 1'b0;

        pw_exp = '0;
        for (int i = 0; i < 7; i++) begin
            st_in = tbl[i].st; w_in = tbl[i].w; vin = tbl[i].v; nbin = tbl[i].nb;
            if (tbl[i].v)
                for (int k = 0; k < 16; k++) pw_exp[k] = tbl[i].w[(k + 4) % 16];
            @(posedge clk); #1;
            chk($sformatf("v%0d valid_o", i), v1o, tbl[i].v);
            chk($sformatf("v%0d newblock_o", i), n1o, tbl[i].v & tbl[i].nb);
            chk($sformatf("v%0d a", i), s1o.a, tbl[i].a);
            chk($sformatf("v%0d e", i), s1o.e, tbl[i].e);
            chk($sformatf("v%0d W15", i), w1o[15], tbl[i].w15);
            chk($sformatf("v%0d W0", i), w1o[0], tbl[i].w0);
            chk($sformatf("v%0d preserve W", i), pw[1], pw_exp);
            if (i == 0) begin
                chk("r2 abc a", s2o.a, 32'h5a6ad9ad);
                chk("r2 abc e", s2o.e, 32'h78ce7989);
                chk("r2 abc W14", w2o[14], 32'h61626380);
                chk("r2 abc W15", w2o[15], 32'h000f0000);
            end
        end

        // Preserve window: per-stage rotation by 4, four stages restore it
        for (int k = 0; k < 16; k++) wseq[k] = k;
        st_in = H_INIT; w_in = wseq; vin = 1'b1; nbin = 1'b0;
        @(posedge clk); #1;
        for (int k = 0; k < 16; k++) wrot[k] = (k + 4) % 16;
        chk("preserve stage W", pw[1], wrot);
        vin = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("preserve chain valid", pv[4], 1'b1);
        chk("preserve chain W", pw[4], wseq);

        // Stall: A loaded, B held under stall, B lands once stall drops
        st_in = sz; w_in = wz; vin = 1'b1;
        @(posedge clk); #1;
        chk("stall A a", s1o.a, 32'h428a2f98);
        w_in = wone; stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk($sformatf("stall%0d valid_o", c), v1o, 1'b1);
            chk($sformatf("stall%0d a", c), s1o.a, 32'h428a2f98);
            chk($sformatf("stall%0d W15", c), w1o[15], 32'h0);
        end
        stall = 1'b0;
        @(posedge clk); #1;
        chk("post-stall B a", s1o.a, 32'h428a2f99);
        chk("post-stall B W15", w1o[15], 32'h1);

        // Reset wins over stall
        rst = 1'b1; stall = 1'b1; vin = 1'b1; nbin = 1'b1;
        @(posedge clk); #1;
        chk("rst+stall valid_o", v1o, 1'b0);
        chk("rst+stall state_o", s1o, '0);
        chk("rst+stall W_o", w1o, '0);
        chk("rst+stall newblock_o", n1o, 1'b0);
        chk("rst+stall r2 valid_o", v2o, 1'b0);
        rst = 1'b0; stall = 1'b0; vin = 1'b0; nbin = 1'b1;
        @(posedge clk); #1;
        chk("nb without valid", n1o, 1'b0);
        chk("idle valid_o", v1o, 1'b0);

        // Full chains: beats at cycles 0, 3, 4
        cnt1 = 0; cnt2 = 0; cnt4 = 0;
        st_in = H_INIT; w_in = abc;
        for (int cyc = 0; cyc < 80; cyc++) begin
            vin  = (cyc == 0 || cyc == 3 || cyc == 4);
            nbin = (cyc == 0);
            @(posedge clk); #1;
            if (cv1[64]) begin
                chk($sformatf("chain1 digest %0d", cnt1), feed_fwd(cs1[64]), DIGEST_ABC);
                chk($sformatf("chain1 newblock %0d", cnt1), cn1[64], cnt1 == 0);
                cnt1++;
            end
            if (cv2[32]) begin
                chk($sformatf("chain2 digest %0d", cnt2), feed_fwd(cs2[32]), DIGEST_ABC);
                cnt2++;
            end
            if (cv4[16]) begin
                chk($sformatf("chain4 digest %0d", cnt4), feed_fwd(cs4[16]), DIGEST_ABC);
                chk($sformatf("chain4 newblock %0d", cnt4), cn4[16], cnt4 == 0);
                cnt4++;
            end
        end
        chk("chain1 beats", cnt1, 3);
        chk("chain2 beats", cnt2, 3);
        chk("chain4 beats", cnt4, 3);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
